// File: rtl/pc_next_unit_if.sv
// Bundle of PC-side, request and result signals for pc_next_unit.
// The unit connects through the slave modport; whoever drives the PC side uses master.
interface pc_next_unit_if #(
  parameter int WIDTH  = 32,
  parameter int PERIOD = 10
);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [WIDTH-1:0] pc_in;
  logic             stall;
  logic             br_req;
  logic [WIDTH-1:0] br_offset;
  logic             jmp_req;
  logic [WIDTH-1:0] jmp_target;
  logic [WIDTH-1:0] next_addr;
  logic             next_valid;
  logic [PW-1:0]    phase;
  logic             misalign;

  modport master (
    output pc_in, stall, br_req, br_offset, jmp_req, jmp_target,
    input  next_addr, next_valid, phase, misalign
  );

  modport slave (
    input  pc_in, stall, br_req, br_offset, jmp_req, jmp_target,
    output next_addr, next_valid, phase, misalign
  );
endinterface

// File: rtl/pc_next_unit.sv
// Next-address generator: once per PERIOD-cycle slot loads PC+STEP, PC+branch offset or a jump target.
// Optional alignment trap enabled by defining PC_NEXT_TRAP_EN.
module pc_next_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] STEP       = 1,
  parameter int               PERIOD     = 10,
  parameter logic [WIDTH-1:0] RESET_ADDR = 1,
  parameter int               ALIGN      = 0
) (
  input logic          clock,
  input logic          reset,
  pc_next_unit_if.slave bus
);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] UPD  = PW'(1 % PERIOD);
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN) - WIDTH'(1);

`ifdef PC_NEXT_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [PW-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0] nextAddr_q, nextAddr_d;
  logic             nextValid_q;
  logic             misalign_q;
  logic             pendBrValid_q, pendJmpValid_q;
  logic [WIDTH-1:0] pendBr_q, pendJmp_q;
  logic             update;
  logic             trapHit;
  logic [WIDTH-1:0] selAddr;

  // Live requests take priority over latched ones; jumps beat branches.
  always_comb begin
    phase_d = phase_q;
    if (!bus.stall) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end
    update = (phase_q == UPD) && !bus.stall;

    if (bus.jmp_req) begin
      selAddr = bus.jmp_target;
    end else if (pendJmpValid_q) begin
      selAddr = pendJmp_q;
    end else if (bus.br_req) begin
      selAddr = bus.pc_in + bus.br_offset;
    end else if (pendBrValid_q) begin
      selAddr = bus.pc_in + pendBr_q;
    end else begin
      selAddr = bus.pc_in + STEP;
    end

    trapHit    = TRAP_EN && ((selAddr & ALIGN_MASK) != '0);
    nextAddr_d = nextAddr_q;
    if (update) begin
      nextAddr_d = trapHit ? RESET_ADDR : selAddr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q        <= '0;
      nextAddr_q     <= RESET_ADDR;
      nextValid_q    <= 1'b0;
      misalign_q     <= 1'b0;
      pendBrValid_q  <= 1'b0;
      pendJmpValid_q <= 1'b0;
      pendBr_q       <= '0;
      pendJmp_q      <= '0;
    end else begin
      phase_q     <= phase_d;
      nextAddr_q  <= nextAddr_d;
      nextValid_q <= update;
      misalign_q  <= update && trapHit;
      // The update edge consumes everything, including a same-cycle request.
      if (update) begin
        pendBrValid_q  <= 1'b0;
        pendJmpValid_q <= 1'b0;
      end else begin
        if (bus.br_req) begin
          pendBrValid_q <= 1'b1;
          pendBr_q      <= bus.br_offset;
        end
        if (bus.jmp_req) begin
          pendJmpValid_q <= 1'b1;
          pendJmp_q      <= bus.jmp_target;
        end
      end
    end
  end

  assign bus.next_addr  = nextAddr_q;
  assign bus.next_valid = nextValid_q;
  assign bus.phase      = phase_q;
  assign bus.misalign   = misalign_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench: dutA (PERIOD=10, STEP=4, ALIGN=2) against a slot-count model,
// dutB (PERIOD=1, STEP=1) expecting PC+1 on every edge.
module tb_pc_next_unit;
  localparam int          PERIOD     = 10;
  localparam int          ALIGN      = 2;
  localparam logic [31:0] STEP       = 32'd4;
  localparam logic [31:0] RESET_ADDR = 32'd1;

  typedef struct {
    logic [31:0] addr;
    logic        mis;
  } expT;

  logic clock = 1'b0;
  logic resetA = 1'b0;
  logic resetB = 1'b0;
  always #5 clock = ~clock;

  pc_next_unit_if #(.WIDTH(32), .PERIOD(PERIOD)) busA ();
  pc_next_unit_if #(.WIDTH(32), .PERIOD(1))      busB ();

  pc_next_unit #(.WIDTH(32), .STEP(STEP), .PERIOD(PERIOD), .RESET_ADDR(RESET_ADDR), .ALIGN(ALIGN))
    dutA (.clock(clock), .reset(resetA), .bus(busA));
  pc_next_unit #(.WIDTH(32), .STEP(32'd1), .PERIOD(1), .RESET_ADDR(RESET_ADDR), .ALIGN(0))
    dutB (.clock(clock), .reset(resetB), .bus(busB));

  int          checks = 0;
  int          errors = 0;
  expT         expQ[$];
  logic [31:0] expB[$];
  int          slotCount = 0;
  bit          pendBr = 0, pendJmp = 0;
  logic [31:0] pendBrOff = 0, pendJmpTgt = 0;
  int          expPhase = 0;
  bit          expValid = 0;
  logic [31:0] lastAddr = RESET_ADDR;
  logic [31:0] curPc = 32'h10;
  logic [31:0] lastPcB = 32'h10;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs and advances the slot-count model for the coming edge.
  task automatic applyStimulus(input bit st, input bit br, input logic [31:0] off,
                               input bit jp, input logic [31:0] tgt, input logic [31:0] pc);
    logic [31:0] a;
    bit          mis;
    bit          upd;
    @(negedge clock);
    busA.pc_in = pc; busA.stall = st; busA.br_req = br; busA.br_offset = off;
    busA.jmp_req = jp; busA.jmp_target = tgt;
    busB.pc_in = pc; lastPcB = pc;
    expB.push_back(pc + 32'd1);
    upd = !st && ((slotCount % PERIOD) == (1 % PERIOD));
    if (upd) begin
      if (jp) a = tgt;
      else if (pendJmp) a = pendJmpTgt;
      else if (br) a = pc + off;
      else if (pendBr) a = pc + pendBrOff;
      else a = pc + STEP;
      mis = 1'b0;
`ifdef PC_NEXT_TRAP_EN
      if ((a & ((32'd1 << ALIGN) - 32'd1)) != 32'd0) begin
        a = RESET_ADDR;
        mis = 1'b1;
      end
`endif
      expQ.push_back('{a, mis});
      pendBr = 0;
      pendJmp = 0;
    end else begin
      if (br) begin pendBr = 1; pendBrOff = off; end
      if (jp) begin pendJmp = 1; pendJmpTgt = tgt; end
    end
    if (!st) slotCount++;
    expPhase = slotCount % PERIOD;
    expValid = upd;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 32'd0, 0, 32'd0, curPc);
  endtask

  task automatic runToUpdate();
    int n = 0;
    do begin
      idle();
      n++;
    end while (!expValid && n < 2 * PERIOD);
    @(posedge clock);
    #2;
  endtask

  task automatic waitPhase(input int p);
    int n = 0;
    while (expPhase != p && n < 2 * PERIOD) begin
      idle();
      n++;
    end
  endtask

  task automatic resetDutA();
    @(negedge clock);
    resetA = 1'b1;
    busA.br_req = 0; busA.jmp_req = 0; busA.stall = 0;
    expB.push_back(lastPcB + 32'd1);
    slotCount = 0; pendBr = 0; pendJmp = 0; expPhase = 0; expValid = 0;
    expQ.delete();
    @(posedge clock);
    #2;
    resetA = 1'b0;
  endtask

  // Monitor for dutA: scoreboard pop on every expected update, hold check otherwise.
  initial begin
    expT e;
    forever begin
      @(posedge clock);
      #1;
      if (resetA) begin
        checkOutput("rstPhase", 32'(busA.phase), 32'd0);
        checkOutput("rstValid", 32'(busA.next_valid), 32'd0);
        checkOutput("rstAddr", busA.next_addr, RESET_ADDR);
        checkOutput("rstMisalign", 32'(busA.misalign), 32'd0);
        lastAddr = RESET_ADDR;
      end else begin
        checkOutput("phase", 32'(busA.phase), 32'(expPhase));
        checkOutput("nextValid", 32'(busA.next_valid), 32'(expValid));
        if (expValid) begin
          if (expQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL scoreboardEmpty: got update, expected none queued");
          end else begin
            e = expQ.pop_front();
            checkOutput("nextAddr", busA.next_addr, e.addr);
            checkOutput("misalign", 32'(busA.misalign), 32'(e.mis));
            lastAddr = e.addr;
          end
        end else begin
          checkOutput("holdAddr", busA.next_addr, lastAddr);
          checkOutput("misalignIdle", 32'(busA.misalign), 32'd0);
        end
      end
    end
  end

  // Monitor for dutB: with a one-cycle slot every edge is an update.
  initial begin
    logic [31:0] eb;
    forever begin
      @(posedge clock);
      #1;
      if (resetB) begin
        checkOutput("bRstValid", 32'(busB.next_valid), 32'd0);
        checkOutput("bRstAddr", busB.next_addr, RESET_ADDR);
      end else if (expB.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL bScoreboardEmpty: got edge, expected none queued");
      end else begin
        eb = expB.pop_front();
        checkOutput("bValid", 32'(busB.next_valid), 32'd1);
        checkOutput("bAddr", busB.next_addr, eb);
      end
    end
  end

  initial begin
    logic [31:0] pc, off, tgt;
    bit          st, br, jp;
    busA.pc_in = 32'h10; busA.stall = 0; busA.br_req = 0; busA.br_offset = 0;
    busA.jmp_req = 0; busA.jmp_target = 0;
    busB.pc_in = 32'h10; busB.stall = 0; busB.br_req = 0; busB.br_offset = 0;
    busB.jmp_req = 0; busB.jmp_target = 0;
    #1;
    resetA = 1'b1;
    resetB = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    resetA = 1'b0;
    resetB = 1'b0;

    // First update on the second edge, then every PERIOD edges.
    curPc = 32'h10;
    repeat (2) idle();
    @(posedge clock); #2;
    checkOutput("firstAddr", busA.next_addr, 32'h14);
    checkOutput("firstValid", 32'(busA.next_valid), 32'd1);
    repeat (PERIOD) idle();
    @(posedge clock); #2;
    checkOutput("secondValid", 32'(busA.next_valid), 32'd1);

    // Negative branch offset.
    curPc = 32'h40;
    waitPhase(5);
    applyStimulus(0, 1, 32'hFFFF_FFF8, 0, 32'd0, curPc);
    runToUpdate();
    checkOutput("branchAddr", busA.next_addr, 32'h38);
    runToUpdate();
    checkOutput("afterBranch", busA.next_addr, 32'h44);

    // Jump beats a branch from the same slot; the branch is discarded.
    waitPhase(3);
    applyStimulus(0, 1, 32'h100, 0, 32'd0, curPc);
    waitPhase(6);
    applyStimulus(0, 0, 32'd0, 1, 32'h200, curPc);
    runToUpdate();
    checkOutput("jumpWins", busA.next_addr, 32'h200);
    runToUpdate();
    checkOutput("branchDropped", busA.next_addr, 32'h44);

    // Stall across the update phase.
    waitPhase(1);
    repeat (3) begin
      applyStimulus(1, 0, 32'd0, 0, 32'd0, curPc);
      @(posedge clock); #2;
      checkOutput("stallPhase", 32'(busA.phase), 32'd1);
      checkOutput("stallNoValid", 32'(busA.next_valid), 32'd0);
    end
    idle();
    @(posedge clock); #2;
    checkOutput("stallRelease", 32'(busA.next_valid), 32'd1);
    idle();
    @(posedge clock); #2;
    checkOutput("singlePulse", 32'(busA.next_valid), 32'd0);

    // Address wrap on both instances.
    curPc = 32'hFFFF_FFFC;
    runToUpdate();
    checkOutput("wrapA", busA.next_addr, 32'h0);
    applyStimulus(0, 0, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
    @(posedge clock); #2;
    checkOutput("wrapB", busB.next_addr, 32'h0);

    // Misaligned jump target.
    curPc = 32'h80;
    waitPhase(4);
    applyStimulus(0, 0, 32'd0, 1, 32'h202, curPc);
    runToUpdate();
`ifdef PC_NEXT_TRAP_EN
    checkOutput("trapAddr", busA.next_addr, RESET_ADDR);
    checkOutput("trapFlag", 32'(busA.misalign), 32'd1);
`else
    checkOutput("trapAddr", busA.next_addr, 32'h202);
    checkOutput("trapFlag", 32'(busA.misalign), 32'd0);
`endif
    waitPhase(4);
    applyStimulus(0, 0, 32'd0, 1, 32'h200, curPc);
    runToUpdate();
    checkOutput("alignedJump", busA.next_addr, 32'h200);
    checkOutput("alignedFlag", 32'(busA.misalign), 32'd0);

    // Reset mid-slot drops a pending jump.
    waitPhase(4);
    applyStimulus(0, 0, 32'd0, 1, 32'h300, curPc);
    resetDutA();
    repeat (2) idle();
    @(posedge clock); #2;
    checkOutput("pendingLost", busA.next_addr, 32'h84);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0: pc = 32'hFFFF_FFFF;
        1: pc = 32'hFFFF_FFFC;
        2: pc = $urandom;
        default: pc = $urandom & 32'hFFFF_FFFC;
      endcase
      st  = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 9) == 0);
      jp  = ($urandom_range(0, 15) == 0);
      off = 32'($urandom_range(0, 64)) - 32'd32;
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      curPc = pc;
      applyStimulus(st, br, off, jp, tgt, pc);
      if (i == 300) resetDutA();
    end

    repeat (3) idle();
    @(posedge clock); #2;
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised next-address generator for the multicycle datapath, replacing the fixed PC+1 adder. A free-running phase counter divides the clock into instruction slots of PERIOD cycles. Once per slot the block produces the next program address: sequential (PC+STEP), PC-relative branch or absolute jump, with stall support and pending-request capture. It sits between the PC register (feeds `pc_in`) and the PC write mux (consumes `next_addr`).

## Interface
- WIDTH, 32: address width.
- STEP, 1: sequential increment added to `pc_in`.
- PERIOD, 10: cycles per instruction slot (≥1).
- RESET_ADDR, 1: `next_addr` value after reset.
- ALIGN, 0: log2 of required address alignment; used only with the trap feature.
- PW, derived = max(1, $clog2(PERIOD)): phase width (localparam).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- pc_in  in  WIDTH  current PC
- stall  in  1  freeze phase counter and updates
- br_req  in  1  branch request (one-cycle pulse, captured)
- br_offset  in  WIDTH  signed two's-complement branch offset, sampled with br_req
- jmp_req  in  1  jump request (one-cycle pulse, captured)
- jmp_target  in  WIDTH  absolute target, sampled with jmp_req
- next_addr  out  WIDTH  registered next PC
- next_valid  out  1  one-cycle pulse: `next_addr` just updated
- phase  out  PW  current phase, 0..PERIOD-1
- misalign  out  1  trap flag (only with PC_NEXT_TRAP_EN; tied 0 otherwise)

## Operation
- Reset (async): phase=0, next_addr=RESET_ADDR, next_valid=0, misalign=0, pending branch/jump cleared.
- Phase counter: +1 per edge when !stall, wraps PERIOD-1→0. UPD = 1 % PERIOD (UPD=0 when PERIOD=1).
- Request capture: on any edge, br_req=1 latches br_offset into pend_br; jmp_req=1 latches jmp_target into pend_jmp. A later request of the same kind overwrites the earlier one.
- Update: on an edge with phase==UPD and !stall, next_addr loads:
  - jump pending or jmp_req this cycle → target (live input wins over latched);
  - else branch pending or br_req this cycle → pc_in + offset;
  - else → pc_in + STEP.
  - Both pending registers clear on the update edge, including any losing branch.
- Arithmetic: modulo 2^WIDTH, carries discarded; offset sign-correct at WIDTH.
- Stall at phase UPD: update deferred until stall drops; requests still captured.
- next_valid is 1 exactly in the cycle following an update edge, otherwise 0.

## Timing
- First update: second rising edge after reset release (phase 0→1, then update at phase 1). With PERIOD=1: first edge, then every edge.
- Update latency: one edge from sampled pc_in/requests to next_addr; next_valid coincident with new value.
- Updates are exactly PERIOD edges apart absent stall; each stalled cycle adds one.
- Reset mid-slot: immediate return to reset values; pending requests lost.

## Configuration
- PC_NEXT_TRAP_EN defined: on each update, if the selected address has any of its low ALIGN bits set, next_addr loads RESET_ADDR instead and misalign pulses with next_valid. With ALIGN=0 it never fires.
- Undefined: no check; misalign constant 0; the chosen address is loaded unconditionally.

## Test plan
- Reset, pc_in=0x10, PERIOD=10, STEP=4 → next_addr=1 until 2nd edge; then 0x14 with next_valid pulse; next pulse 10 edges later.
- br_req pulse at phase 5, offset=0xFFFFFFF8, pc_in=0x40 → at next update next_addr=0x38; following slot returns to pc_in+STEP.
- jmp_req (target 0x200) and br_req in the same slot → next_addr=0x200; next slot sequential (branch discarded).
- stall high for 3 cycles at phase 1 → update delayed 3 edges; phase holds at 1; next_valid single pulse.
- pc_in=0xFFFFFFFF, STEP=1 → next_addr=0 (wrap); PERIOD=1 → next_valid high every cycle.
- With PC_NEXT_TRAP_EN, ALIGN=2: jump to 0x202 → next_addr=RESET_ADDR, misalign=1 for one cycle; jump to 0x200 → misalign=0.
